// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Summary  : Single-outstanding load/store stage with an ADDR/DATA bus cycle
//            and sign/zero extension of load data. Optional misalignment trap
//            is enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] bus_addr,
    output logic [1:0]  bus_size,
    output logic        bus_rw,
    output logic [31:0] bus_wdata,
    output logic        bus_wdata_oe,
    input  logic [31:0] bus_rdata,
    output logic        perf_inc
);

    localparam logic [1:0] c_SIZE_NOP  = 2'b00;
    localparam logic [1:0] c_SIZE_BYTE = 2'b01;
    localparam logic [1:0] c_SIZE_HALF = 2'b10;
    localparam logic [1:0] c_SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;

    logic        w_fault;
    logic [31:0] w_bus_addr;
    logic [31:0] w_ext_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_fault    = ((req_size == c_SIZE_HALF) && req_addr[0]) ||
                        ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign w_bus_addr = req_addr;
`else
    // Halves drop addr[0], words drop addr[1:0]; bytes pass through.
    assign w_fault    = 1'b0;
    assign w_bus_addr = {req_addr[31:2],
                         req_addr[1] & (req_size != c_SIZE_WORD),
                         req_addr[0] & ~req_size[1]};
`endif

    always_comb begin
        w_ext_rdata = bus_rdata;
        case (r_size)
            c_SIZE_BYTE: w_ext_rdata = {{24{~r_unsigned & bus_rdata[7]}},  bus_rdata[7:0]};
            c_SIZE_HALF: w_ext_rdata = {{16{~r_unsigned & bus_rdata[15]}}, bus_rdata[15:0]};
            default:     w_ext_rdata = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_size       <= c_SIZE_NOP;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_fault   <= 1'b0;
            perf_inc     <= 1'b0;
            bus_addr     <= IDLE_ADDR;
            bus_size     <= c_SIZE_NOP;
            bus_rw       <= 1'b1;
            bus_wdata    <= '0;
            bus_wdata_oe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_write    <= req_write;
                        r_unsigned <= req_unsigned;
                        req_ready  <= 1'b0;
                        if ((req_size == c_SIZE_NOP) || w_fault) begin
                            // No bus cycle: answer directly with empty data.
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_fault <= w_fault;
                            perf_inc   <= 1'b0;
                        end else begin
                            r_state      <= S_ADDR;
                            bus_addr     <= w_bus_addr;
                            bus_size     <= req_size;
                            bus_rw       <= req_write;
                            bus_wdata_oe <= req_write;
                            bus_wdata    <= req_write ? req_wdata : '0;
                        end
                    end
                end
                S_ADDR: begin
                    // Hold phase keeps rw high so a read strobe is seen only once.
                    r_state      <= S_DATA;
                    bus_rw       <= 1'b1;
                    bus_wdata_oe <= 1'b0;
                    bus_wdata    <= '0;
                end
                S_DATA: begin
                    r_state      <= S_RESP;
                    bus_addr     <= IDLE_ADDR;
                    bus_size     <= c_SIZE_NOP;
                    bus_rw       <= 1'b1;
                    bus_wdata_oe <= 1'b0;
                    bus_wdata    <= '0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= r_write ? 32'h0 : w_ext_rdata;
                    resp_fault   <= 1'b0;
                    perf_inc     <= 1'b1;
                end
                S_RESP: begin
                    perf_inc <= 1'b0;
                    if (resp_ready) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Summary  : Scoreboard bench for load_store_unit with directed accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_write = 1'b0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] bus_addr;
    logic [1:0]  bus_size;
    logic        bus_rw;
    logic [31:0] bus_wdata;
    logic        bus_wdata_oe;
    logic [31:0] bus_rdata = '0;
    logic        perf_inc;

    int tests  = 0;
    int failed = 0;
    int perf_cnt = 0;
    logic [32:0] expq[$];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_write(req_write), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .bus_addr(bus_addr), .bus_size(bus_size), .bus_rw(bus_rw),
        .bus_wdata(bus_wdata), .bus_wdata_oe(bus_wdata_oe),
        .bus_rdata(bus_rdata), .perf_inc(perf_inc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (perf_inc === 1'b1) perf_cnt++;
            if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                tests++;
                if (expq.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_resp: got rdata %h fault %b expected none",
                             resp_rdata, resp_fault);
                end else begin
                    e = expq.pop_front();
                    if ({resp_fault, resp_rdata} !== e) begin
                        failed++;
                        $display("FAIL resp: got fault %b rdata %h expected fault %b rdata %h",
                                 resp_fault, resp_rdata, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic drive_req(input logic [31:0] addr, input logic [1:0] size,
                             input logic wr, input logic uns, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_size = size;
        req_write = wr; req_unsigned = uns; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        chk("req_ready_return", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic access(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic wr, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [31:0] exp_rdata,
                          input logic exp_fault, input logic [31:0] exp_addr);
        int  p0;
        bit  exp_bus;
        exp_bus = (size != 2'b00) && !exp_fault;
        p0 = perf_cnt;
        expq.push_back({exp_fault, exp_rdata});
        drive_req(addr, size, wr, uns, wdata);
        @(negedge clk);
        if (exp_bus) begin
            chk({name, "_addr_size"}, {30'd0, bus_size}, {30'd0, size});
            chk({name, "_addr_addr"}, bus_addr, exp_addr);
            chk({name, "_addr_rw_oe"}, {30'd0, bus_rw, bus_wdata_oe}, {30'd0, wr, wr});
            if (wr) chk({name, "_addr_wdata"}, bus_wdata, wdata);
            bus_rdata = rdata;
            @(negedge clk);
            chk({name, "_data_bus"}, {bus_addr[29:0], bus_size}, {exp_addr[29:0], size});
            chk({name, "_data_rw_oe"}, {30'd0, bus_rw, bus_wdata_oe}, 32'd2);
            @(negedge clk);
            bus_rdata = '0;
            chk({name, "_c3_valid"}, {31'd0, resp_valid}, 32'd1);
        end else begin
            chk({name, "_c1_valid"}, {31'd0, resp_valid}, 32'd1);
        end
        chk({name, "_idle_bus"}, {bus_size, bus_rw, bus_wdata_oe, 28'd0}, {2'b00, 1'b1, 1'b0, 28'd0});
        chk({name, "_idle_addr_wd"}, bus_addr | bus_wdata, 32'd0);
        wait_ready();
        chk({name, "_perf"}, perf_cnt - p0, exp_bus ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] held_rdata;
        logic        held_fault;
        int          p0;
        bit          seen_resp;

        repeat (2) @(negedge clk);
        chk("rst_ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
        chk("rst_resp", {resp_rdata[30:0], resp_fault}, 32'd0);
        chk("rst_bus", {bus_size, bus_rw, bus_wdata_oe, perf_inc, 27'd0}, {2'b00, 1'b1, 1'b0, 1'b0, 27'd0});
        chk("rst_bus_addr", bus_addr | bus_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access("ldw",   32'h8000_0000, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h8000_0000);
        access("ldb_s", 32'h8000_0001, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0000_0080, 32'hFFFF_FF80, 1'b0, 32'h8000_0001);
        access("ldb_u", 32'h8000_0003, 2'b01, 1'b0, 1'b1, 32'h0, 32'h0000_0080, 32'h0000_0080, 1'b0, 32'h8000_0003);
        access("ldh_s", 32'h8000_0000, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_8001, 32'hFFFF_8001, 1'b0, 32'h8000_0000);
        access("ldh_u", 32'h8000_0002, 2'b10, 1'b0, 1'b1, 32'h0, 32'hABCD_8001, 32'h0000_8001, 1'b0, 32'h8000_0002);
        access("stw",   32'h8000_0000, 2'b11, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0, 32'h8000_0000);
        access("nop",   32'h8000_0004, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1111_1111, 32'h0, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("misw",  32'h8000_0002, 2'b11, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 32'h0);
        access("mish",  32'h8000_0001, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_7FFF, 32'h0, 1'b1, 32'h0);
`else
        access("misw",  32'h8000_0002, 2'b11, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h8000_0000);
        access("mish",  32'h8000_0001, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 32'h8000_0000);
`endif

        // Backpressure: response held across three cycles.
        p0 = perf_cnt;
        @(negedge clk);
        resp_ready = 1'b0;
        expq.push_back({1'b0, 32'hFFFF_FFA5});
        drive_req(32'h8000_0008, 2'b01, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        bus_rdata = 32'h0000_00A5;
        @(negedge clk);
        @(negedge clk);
        bus_rdata = '0;
        chk("bp_c3_valid", {31'd0, resp_valid}, 32'd1);
        held_rdata = resp_rdata;
        held_fault = resp_fault;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_hold_valid_ready", {30'd0, resp_valid, req_ready}, 32'd2);
            chk("bp_hold_rdata", resp_rdata, held_rdata);
            chk("bp_hold_fault", {31'd0, resp_fault}, {31'd0, held_fault});
            chk("bp_hold_perf", {31'd0, perf_inc}, 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_ready();
        chk("bp_perf_once", perf_cnt - p0, 32'd1);

        // Reset during DATA aborts the access.
        p0 = perf_cnt;
        drive_req(32'h8000_0000, 2'b11, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        bus_rdata = 32'h5555_5555;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_rdata = '0;
        chk("rstd_bus_size", {30'd0, bus_size}, 32'd0);
        chk("rstd_valid_ready", {30'd0, resp_valid, req_ready}, 32'd1);
        seen_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen_resp = 1'b1;
        end
        chk("rstd_no_resp", {31'd0, seen_resp}, 32'd0);
        chk("rstd_no_perf", perf_cnt - p0, 32'd0);

        // Unit still works after the aborted access.
        access("post_rst", 32'h8000_0010, 2'b11, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'h8000_0010);

        chk("scoreboard_empty", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
